// File: rtl/spill_fifo_flushable.sv
// Flushable valid/ready elastic buffer with configurable depth; every output is
// derived from registered state, so the data and ready paths are both cut.
module spill_fifo_flushable #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2,
  parameter bit          Bypass    = 1'b0,
  parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [CntWidth-1:0]  usage_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  if (Bypass) begin : gen_bypass
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign usage_o = '0;
    assign full_o  = 1'b0;
    assign empty_o = 1'b0;
  end else begin : gen_fifo
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  rd_q;
    logic [PtrWidth-1:0]  wr_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 push;
    logic                 pop;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    assign ready_o = (cnt_q != FullCnt);
    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_q];
    assign usage_o = cnt_q;
    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);

    // A handshake in a flush cycle is void on both sides.
    assign push = valid_i & ready_o & ~flush_i;
    assign pop  = valid_o & ready_i & ~flush_i;

    // Storage array; flush leaves contents in place, which keeps data_o X-free.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          mem_q[i] <= '0;
        end
      end else if (push) begin
        mem_q[wr_q] <= data_i;
      end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) begin
          wr_q <= next_ptr(wr_q);
        end
        if (pop) begin
          rd_q <= next_ptr(rd_q);
        end
        if (push && !pop) begin
          cnt_q <= cnt_q + CntWidth'(1);
        end else if (pop && !push) begin
          cnt_q <= cnt_q - CntWidth'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spill_fifo_flushable.sv
// Directed bench for spill_fifo_flushable: vector table on a Depth=4 instance,
// plus streaming (Depth=2), wrap-around (Depth=3) and bypass sequences.
module tb_spill_fifo_flushable;

  logic       clk = 1'b0;
  logic       rst_i, flush_i, valid_i, ready_i;
  logic [7:0] data_i;

  logic       r4, v4, f4, e4;
  logic [7:0] d4;
  logic [2:0] u4;
  logic       r2, v2, f2, e2;
  logic [7:0] d2;
  logic [1:0] u2;
  logic       r3, v3, f3, e3;
  logic [7:0] d3;
  logic [1:0] u3;
  logic       rb, vb, fb, eb;
  logic [7:0] db;
  logic [1:0] ub;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spill_fifo_flushable #(.DataWidth(8), .Depth(4)) u_d4 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r4),
    .data_i(data_i), .valid_o(v4), .ready_i(ready_i), .data_o(d4), .usage_o(u4),
    .full_o(f4), .empty_o(e4));

  spill_fifo_flushable #(.DataWidth(8), .Depth(2)) u_d2 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r2),
    .data_i(data_i), .valid_o(v2), .ready_i(ready_i), .data_o(d2), .usage_o(u2),
    .full_o(f2), .empty_o(e2));

  spill_fifo_flushable #(.DataWidth(8), .Depth(3)) u_d3 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r3),
    .data_i(data_i), .valid_o(v3), .ready_i(ready_i), .data_o(d3), .usage_o(u3),
    .full_o(f3), .empty_o(e3));

  spill_fifo_flushable #(.DataWidth(8), .Depth(2), .Bypass(1'b1)) u_byp (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rb),
    .data_i(data_i), .valid_o(vb), .ready_i(ready_i), .data_o(db), .usage_o(ub),
    .full_o(fb), .empty_o(eb));

  typedef struct {
    logic       rst, flush, valid, ready;
    logic [7:0] data;
    logic       ev, er;
    logic [7:0] ed;
    logic [2:0] eu;
    logic       ef, ee, chk_d;
  } vec_t;

  localparam int unsigned NVec = 23;
  vec_t vecs [NVec];

  function automatic vec_t mk(input logic rst, flush, valid, ready, input logic [7:0] data,
                              input logic ev, er, input logic [7:0] ed, input logic [2:0] eu,
                              input logic ef, ee, chk_d);
    vec_t v;
    v.rst = rst; v.flush = flush; v.valid = valid; v.ready = ready; v.data = data;
    v.ev = ev; v.er = er; v.ed = ed; v.eu = eu; v.ef = ef; v.ee = ee; v.chk_d = chk_d;
    return v;
  endfunction

  task automatic drive(input logic rst, flush, valid, ready, input logic [7:0] data);
    rst_i = rst; flush_i = flush; valid_i = valid; ready_i = ready; data_i = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Inputs are applied after each edge and applied at the next; outputs checked #1 after it.
    vecs[0]  = mk(1, 0, 0, 0, 8'h00,  0, 1, 8'h00, 0, 0, 1, 1);
    vecs[1]  = mk(1, 0, 0, 0, 8'h00,  0, 1, 8'h00, 0, 0, 1, 1);
    vecs[2]  = mk(0, 0, 1, 0, 8'h11,  1, 1, 8'h11, 1, 0, 0, 1);
    vecs[3]  = mk(0, 0, 1, 0, 8'h22,  1, 1, 8'h11, 2, 0, 0, 1);
    vecs[4]  = mk(0, 0, 1, 0, 8'h33,  1, 1, 8'h11, 3, 0, 0, 1);
    vecs[5]  = mk(0, 0, 1, 0, 8'h44,  1, 0, 8'h11, 4, 1, 0, 1);
    vecs[6]  = mk(0, 0, 1, 0, 8'h55,  1, 0, 8'h11, 4, 1, 0, 1);
    vecs[7]  = mk(0, 0, 0, 1, 8'h00,  1, 1, 8'h22, 3, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 1, 8'h00,  1, 1, 8'h33, 2, 0, 0, 1);
    vecs[9]  = mk(0, 0, 1, 0, 8'h66,  1, 1, 8'h33, 3, 0, 0, 1);
    vecs[10] = mk(0, 1, 1, 1, 8'hAA,  0, 1, 8'h00, 0, 0, 1, 0);
    vecs[11] = mk(0, 0, 1, 0, 8'h77,  1, 1, 8'h77, 1, 0, 0, 1);
    vecs[12] = mk(0, 0, 1, 0, 8'h88,  1, 1, 8'h77, 2, 0, 0, 1);
    vecs[13] = mk(1, 0, 0, 0, 8'h00,  0, 1, 8'h00, 0, 0, 1, 1);
    vecs[14] = mk(0, 0, 1, 0, 8'h5A,  1, 1, 8'h5A, 1, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 1, 8'h00,  0, 1, 8'h00, 0, 0, 1, 1);
    vecs[16] = mk(0, 0, 1, 0, 8'h01,  1, 1, 8'h01, 1, 0, 0, 1);
    vecs[17] = mk(0, 0, 1, 0, 8'h02,  1, 1, 8'h01, 2, 0, 0, 1);
    vecs[18] = mk(0, 0, 1, 0, 8'h03,  1, 1, 8'h01, 3, 0, 0, 1);
    vecs[19] = mk(0, 0, 1, 1, 8'h04,  1, 1, 8'h02, 3, 0, 0, 1);
    vecs[20] = mk(0, 0, 0, 1, 8'h00,  1, 1, 8'h03, 2, 0, 0, 1);
    vecs[21] = mk(0, 0, 0, 1, 8'h00,  1, 1, 8'h04, 1, 0, 0, 1);
    vecs[22] = mk(0, 0, 0, 1, 8'h00,  0, 1, 8'h01, 0, 0, 1, 1);

    drive(1, 0, 0, 0, 8'h00);
    #1;

    // Depth=4: reset, fill/hold-off, flush, mid-burst reset, push+pop at Depth-1.
    for (int i = 0; i < int'(NVec); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].valid, vecs[i].ready, vecs[i].data);
      tick();
      n_cmp++;
      if (v4 !== vecs[i].ev || r4 !== vecs[i].er || u4 !== vecs[i].eu ||
          f4 !== vecs[i].ef || e4 !== vecs[i].ee ||
          (vecs[i].chk_d && d4 !== vecs[i].ed) || $isunknown(d4)) begin
        n_bad++;
        $display("FAIL vec%0d: got v=%b r=%b d=%h u=%0d f=%b e=%b, expected v=%b r=%b d=%h(chk %b) u=%0d f=%b e=%b",
                 i, v4, r4, d4, u4, f4, e4, vecs[i].ev, vecs[i].er, vecs[i].ed, vecs[i].chk_d,
                 vecs[i].eu, vecs[i].ef, vecs[i].ee);
      end
    end

    // Depth=2 streaming at full rate.
    drive(1, 0, 0, 0, 8'h00);
    tick();
    for (int k = 0; k < 100; k++) begin
      drive(0, 0, 1, 1, 8'(k));
      tick();
      n_cmp++;
      if (v2 !== 1'b1 || d2 !== 8'(k) || u2 !== 2'd1 || r2 !== 1'b1) begin
        n_bad++;
        $display("FAIL stream%0d: got v=%b d=%h u=%0d r=%b, expected v=1 d=%h u=1 r=1",
                 k, v2, d2, u2, r2, 8'(k));
      end
    end
    drive(0, 0, 0, 1, 8'h00);
    tick();
    n_cmp++;
    if (u2 !== 2'd0 || v2 !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_drain: got u=%0d v=%b, expected u=0 v=0", u2, v2);
    end

    // Depth=3 wrap-around with pseudo-random downstream stalls.
    drive(1, 0, 0, 0, 8'h00);
    tick();
    begin
      int sent = 0;
      int rcvd = 0;
      int mcnt = 0;
      logic psh, pp;
      for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
        drive(0, 0, sent < 10, $urandom_range(0, 2) != 0, 8'(192 + sent));
        psh = valid_i & r3;
        pp  = v3 & ready_i;
        if (pp) begin
          n_cmp++;
          if (d3 !== 8'(192 + rcvd)) begin
            n_bad++;
            $display("FAIL wrap_data%0d: got %h, expected %h", rcvd, d3, 8'(192 + rcvd));
          end
        end
        tick();
        if (psh) begin sent++; mcnt++; end
        if (pp) begin rcvd++; mcnt--; end
        n_cmp++;
        if (u3 !== 2'(mcnt) || mcnt > 3 || r3 !== (mcnt != 3) || v3 !== (mcnt != 0)) begin
          n_bad++;
          $display("FAIL wrap_usage cyc%0d: got u=%0d r=%b v=%b, expected u=%0d", cyc, u3, r3, v3, mcnt);
        end
      end
      n_cmp++;
      if (rcvd != 10) begin
        n_bad++;
        $display("FAIL wrap_count: got %0d beats, expected 10", rcvd);
      end
    end

    // Bypass is pure wiring.
    drive(0, 0, 1, 0, 8'hC3);
    #1;
    n_cmp++;
    if (vb !== 1'b1 || rb !== 1'b0 || db !== 8'hC3 || ub !== 2'd0 || fb !== 1'b0 || eb !== 1'b0) begin
      n_bad++;
      $display("FAIL bypass_a: got v=%b r=%b d=%h u=%0d f=%b e=%b, expected v=1 r=0 d=c3 u=0 f=0 e=0",
               vb, rb, db, ub, fb, eb);
    end
    drive(0, 1, 0, 1, 8'h3C);
    #1;
    n_cmp++;
    if (vb !== 1'b0 || rb !== 1'b1 || db !== 8'h3C) begin
      n_bad++;
      $display("FAIL bypass_b: got v=%b r=%b d=%h, expected v=0 r=1 d=3c", vb, rb, db);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
